// File: rtl/fsm_pulse_decoder.sv
// Pulse-width line decoder: a 1-cycle high pulse is symbol 0, a 3-cycle high
// pulse is symbol 1, any other length is an error. Symbols are packed
// MSB-first into WIDTH-bit words; partial words are dropped on error or on an
// idle gap of GAP_TIMEOUT low samples.
module fsm_pulse_decoder #(
  parameter int WIDTH       = 8,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  output logic                       sym_valid,
  output logic                       sym_bit,
  output logic                       word_valid,
  output logic [WIDTH-1:0]           word_data,
  output logic                       err,
  output logic                       abort,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam int GW  = $clog2(GAP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       run, run_n;
  logic [GW-1:0]    gap, gap_n;
  logic [WIDTH-1:0] shift, shift_n, shifted;
  logic [BCW-1:0]   cnt_n;
  logic [WIDTH-1:0] wdata_n;
  logic             sv_n, sb_n, wv_n, err_n, ab_n;
  logic             dec, dec_bit;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      run        <= '0;
      gap        <= '0;
      shift      <= '0;
      bit_count  <= '0;
      word_data  <= '0;
      sym_valid  <= 1'b0;
      sym_bit    <= 1'b0;
      word_valid <= 1'b0;
      err        <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      run        <= run_n;
      gap        <= gap_n;
      shift      <= shift_n;
      bit_count  <= cnt_n;
      word_data  <= wdata_n;
      sym_valid  <= sv_n;
      sym_bit    <= sb_n;
      word_valid <= wv_n;
      err        <= err_n;
      abort      <= ab_n;
    end
  end

  // Next-state, pulse measurement, classification and word assembly.
  always_comb begin
    state_n = state;
    run_n   = run;
    gap_n   = gap;
    shift_n = shift;
    cnt_n   = bit_count;
    wdata_n = word_data;
    sv_n    = 1'b0;
    sb_n    = 1'b0;
    wv_n    = 1'b0;
    err_n   = 1'b0;
    ab_n    = 1'b0;
    dec     = 1'b0;
    dec_bit = 1'b0;
    shifted = (shift << 1) | WIDTH'(dec_bit);

    case (state)
      IDLE: begin
        if (din) begin
          state_n = HIGH;
          run_n   = 2'd1;
          gap_n   = '0;
        end else begin
          if (gap != GW'(GAP_TIMEOUT)) gap_n = gap + 1'b1;
          // Fires only on the step into GAP_TIMEOUT; a saturated counter with
          // an empty word stays silent.
          if (gap == GW'(GAP_TIMEOUT - 1) && bit_count != '0) begin
            ab_n    = 1'b1;
            cnt_n   = '0;
            shift_n = '0;
          end
        end
      end
      HIGH: begin
        if (din) begin
          if (run == 2'd3) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            shift_n = '0;
            state_n = DRAIN;
          end else begin
            run_n = run + 2'd1;
          end
        end else begin
          state_n = IDLE;
          gap_n   = GW'(1);
          if (run == 2'd2) begin
            err_n   = 1'b1;
            cnt_n   = '0;
            shift_n = '0;
          end else begin
            dec     = 1'b1;
            dec_bit = (run == 2'd3);
          end
        end
      end
      DRAIN: begin
        if (!din) begin
          state_n = IDLE;
          gap_n   = GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (dec) begin
      shifted = (shift << 1) | WIDTH'(dec_bit);
      sv_n    = 1'b1;
      sb_n    = dec_bit;
      if (bit_count == BCW'(WIDTH - 1)) begin
        wv_n    = 1'b1;
        wdata_n = shifted;
        cnt_n   = '0;
        shift_n = '0;
      end else begin
        cnt_n   = bit_count + 1'b1;
        shift_n = shifted;
      end
    end
  end

endmodule

// File: tb/tb_fsm_pulse_decoder.sv
// Self-checking bench for fsm_pulse_decoder with a symbol/word scoreboard.
module tb_fsm_pulse_decoder;

  logic       clk;
  logic       rst;
  logic       din;
  logic       sym_valid;
  logic       sym_bit;
  logic       word_valid;
  logic [7:0] word_data;
  logic       err;
  logic       abort;
  logic [3:0] bit_count;

  int total = 0;
  int bad   = 0;
  int sym_seen = 0, word_seen = 0, err_seen = 0, abort_seen = 0;

  bit         exp_sym[$];
  logic [7:0] exp_word[$];
  logic [7:0] m_shift = '0;
  int         m_cnt = 0;
  logic [7:0] last_word = '0;

  fsm_pulse_decoder #(.WIDTH(8), .GAP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .din(din),
    .sym_valid(sym_valid), .sym_bit(sym_bit),
    .word_valid(word_valid), .word_data(word_data),
    .err(err), .abort(abort), .bit_count(bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pops expected symbols/words as the DUT strobes them.
  always @(negedge clk) begin
    if (rst) begin
      if (sym_valid) begin
        sym_seen++;
        total++;
        if (exp_sym.size() == 0) begin
          bad++;
          $display("FAIL unexpected_sym got=%0b required=none", sym_bit);
        end else begin
          bit e;
          e = exp_sym.pop_front();
          if (sym_bit !== e) begin
            bad++;
            $display("FAIL sym_bit got=%0b required=%0b", sym_bit, e);
          end
        end
      end
      if (word_valid) begin
        word_seen++;
        total++;
        if (exp_word.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word got=%h required=none", word_data);
        end else begin
          logic [7:0] w;
          w = exp_word.pop_front();
          if (word_data !== w) begin
            bad++;
            $display("FAIL word_data got=%h required=%h", word_data, w);
          end
        end
        total++;
        if (sym_valid !== 1'b1) begin
          bad++;
          $display("FAIL word_with_sym got=%0b required=1", sym_valid);
        end
      end
      if (err) err_seen++;
      if (abort) abort_seen++;
      if (err && (sym_valid || abort)) begin
        total++;
        bad++;
        $display("FAIL strobe_exclusive got=err%0b sym%0b abort%0b required=err_alone",
                 err, sym_valid, abort);
      end
    end
  end

  task automatic step(input logic d);
    din = d;
    @(negedge clk);
    #1;
  endtask

  // Sends one legal pulse and records the expected symbol/word in the model.
  task automatic send_sym(input bit b, input int gap);
    exp_sym.push_back(b);
    m_shift = {m_shift[6:0], b};
    m_cnt++;
    if (m_cnt == 8) begin
      exp_word.push_back(m_shift);
      last_word = m_shift;
      m_cnt = 0;
      m_shift = '0;
    end
    for (int i = 0; i < (b ? 3 : 1); i++) step(1'b1);
    for (int i = 0; i < gap; i++) step(1'b0);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_sym(w[i], 1);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_sym.size() != 0 || exp_word.size() != 0) begin
      bad++;
      $display("FAIL %s_queue got=sym%0d word%0d required=0", name, exp_sym.size(), exp_word.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    din = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({sym_valid, sym_bit, word_valid, err, abort} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b required=00000", {sym_valid, sym_bit, word_valid, err, abort});
    end
    total++;
    if (word_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_word got=%h required=00", word_data);
    end
    total++;
    if (bit_count !== 4'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d required=0", bit_count);
    end
    rst = 1'b1;
    step(1'b0);
  endtask

  task automatic test_word;
    int s0, w0;
    bit pat [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    s0 = sym_seen;
    w0 = word_seen;
    for (int i = 0; i < 8; i++) send_sym(pat[i], 1);
    total++;
    if (word_valid !== 1'b1 || sym_valid !== 1'b1) begin
      bad++;
      $display("FAIL word_strobe got=wv%0b sv%0b required=11", word_valid, sym_valid);
    end
    total++;
    if (word_data !== 8'hB2) begin
      bad++;
      $display("FAIL word_B2 got=%h required=b2", word_data);
    end
    total++;
    if (bit_count !== 4'd0) begin
      bad++;
      $display("FAIL word_count got=%0d required=0", bit_count);
    end
    total++;
    if (sym_seen - s0 != 8 || word_seen - w0 != 1) begin
      bad++;
      $display("FAIL word_strobe_count got=sym%0d word%0d required=8,1", sym_seen - s0, word_seen - w0);
    end
    check_drained("word");
  endtask

  task automatic test_short_err;
    int s0;
    send_sym(1'b1, 1);
    send_sym(1'b0, 1);
    send_sym(1'b1, 1);
    total++;
    if (bit_count !== 4'd3) begin
      bad++;
      $display("FAIL pre_err_count got=%0d required=3", bit_count);
    end
    s0 = sym_seen;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    m_cnt = 0;
    m_shift = '0;
    total++;
    if (err !== 1'b1 || sym_valid !== 1'b0 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL short_err got=err%0b sv%0b cnt%0d required=1,0,0", err, sym_valid, bit_count);
    end
    step(1'b0);
    total++;
    if (err !== 1'b0 || sym_seen != s0) begin
      bad++;
      $display("FAIL short_err_once got=err%0b syms%0d required=0,0", err, sym_seen - s0);
    end
    send_word(8'h5A);
    total++;
    if (word_data !== 8'h5A || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL post_err_word got=%h cnt%0d required=5a,0", word_data, bit_count);
    end
    check_drained("short_err");
  endtask

  task automatic test_stuck_high;
    int e0, a0;
    e0 = err_seen;
    a0 = abort_seen;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1);
      if (i == 4) begin
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL stuck_err_edge got=%0b required=1", err);
        end
      end
    end
    step(1'b0);
    total++;
    if (err_seen - e0 != 1 || sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL stuck_err_count got=%0d sv%0b required=1,0", err_seen - e0, sym_valid);
    end
    m_cnt = 0;
    m_shift = '0;
    send_sym(1'b0, 1);
    total++;
    if (sym_valid !== 1'b1 || sym_bit !== 1'b0) begin
      bad++;
      $display("FAIL stuck_recover got=sv%0b sb%0b required=1,0", sym_valid, sym_bit);
    end
    for (int i = 0; i < 20; i++) step(1'b0);
    m_cnt = 0;
    m_shift = '0;
    total++;
    if (abort_seen - a0 != 1 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL stuck_cleanup got=aborts%0d cnt%0d required=1,0", abort_seen - a0, bit_count);
    end
    check_drained("stuck");
  endtask

  task automatic test_gap_abort;
    int a0;
    bit early;
    send_sym(1'b1, 1);
    send_sym(1'b1, 1);
    send_sym(1'b0, 1);
    send_sym(1'b1, 1);
    send_sym(1'b0, 1);
    a0 = abort_seen;
    early = 1'b0;
    for (int i = 2; i <= 15; i++) begin
      step(1'b0);
      if (abort !== 1'b0) early = 1'b1;
    end
    total++;
    if (early || bit_count !== 4'd5) begin
      bad++;
      $display("FAIL abort_early got=early%0b cnt%0d required=0,5", early, bit_count);
    end
    step(1'b0);
    m_cnt = 0;
    m_shift = '0;
    total++;
    if (abort !== 1'b1 || bit_count !== 4'd0 || word_data !== last_word) begin
      bad++;
      $display("FAIL abort_16th got=ab%0b cnt%0d word%h required=1,0,%h", abort, bit_count, word_data, last_word);
    end
    for (int i = 0; i < 40; i++) step(1'b0);
    total++;
    if (abort_seen - a0 != 1) begin
      bad++;
      $display("FAIL idle_no_abort got=%0d required=1", abort_seen - a0);
    end
    check_drained("abort");
  endtask

  task automatic test_async_reset;
    send_sym(1'b1, 1);
    send_sym(1'b0, 1);
    send_sym(1'b1, 1);
    send_sym(1'b1, 1);
    step(1'b1);
    step(1'b1);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({sym_valid, sym_bit, word_valid, err, abort, bit_count, word_data} !== 17'b0) begin
      bad++;
      $display("FAIL async_reset got=%b required=0", {sym_valid, sym_bit, word_valid, err, abort, bit_count, word_data});
    end
    din = 1'b0;
    m_cnt = 0;
    m_shift = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    send_word(8'hC3);
    total++;
    if (word_data !== 8'hC3 || bit_count !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_word got=%h cnt%0d required=c3,0", word_data, bit_count);
    end
    check_drained("async_reset");
  endtask

  task automatic test_random_gen;
    int e0, a0, w0;
    e0 = err_seen;
    a0 = abort_seen;
    w0 = word_seen;
    for (int i = 0; i < 32; i++) send_sym(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    repeat (2) step(1'b0);
    total++;
    if (err_seen != e0 || abort_seen != a0 || word_seen - w0 != 4) begin
      bad++;
      $display("FAIL random_gen got=err%0d abort%0d words%0d required=0,0,4",
               err_seen - e0, abort_seen - a0, word_seen - w0);
    end
    check_drained("random_gen");
  endtask

  initial begin
    test_reset();
    test_word();
    test_short_err();
    test_stuck_high();
    test_gap_abort();
    test_async_reset();
    test_random_gen();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_pulse_decoder.md
Name: fsm_pulse_decoder

Overview:
- Receive-side decoder for the single-wire pulse-width line driven by the 3-cycle-high pulse generator FSM.
- Samples the line, measures each high pulse, and classifies it: 1 cycle = symbol 0, 3 cycles = symbol 1, any other length = error.
- Shifts decoded symbols MSB-first into a WIDTH-bit word and flags word completion; drops partial words on error or idle timeout.

Parameters:
- WIDTH, 8, number of symbols per word (>= 1)
- GAP_TIMEOUT, 16, consecutive low samples with a partial word pending before the word is aborted (>= 2)

Ports:
- clk  input  1  clock; all sampling on rising edge
- rst  input  1  asynchronous, active-low reset
- din  input  1  pulse line from the generator
- sym_valid  output  1  one-cycle strobe: a symbol was decoded
- sym_bit  output  1  decoded symbol value; meaningful only while sym_valid=1
- word_valid  output  1  one-cycle strobe: word_data holds a complete word
- word_data  output  WIDTH  last completed word; first-received symbol in bit WIDTH-1
- err  output  1  one-cycle strobe: illegal pulse length; partial word discarded
- abort  output  1  one-cycle strobe: gap timeout; partial word discarded
- bit_count  output  clog2(WIDTH+1)  symbols held in the current partial word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, run counter=0, gap counter=0, shift register=0, bit_count=0, word_data=0, and all strobes=0. Release is synchronous to clk.
- All outputs are registered. Every strobe is high for exactly the cycle after the clk edge that causes it.
- Run length L is the number of consecutive rising-edge samples with din=1.
- State IDLE:
  - din=1: go to HIGH with run=1 and clear the gap counter.
  - din=0: increment the gap counter, saturating at GAP_TIMEOUT.
  - When the gap counter reaches GAP_TIMEOUT with bit_count!=0: assert abort, clear bit_count and the shift register. With bit_count=0, no abort ever fires.
- State HIGH:
  - din=1 and run<3: run+1.
  - din=1 and run=3 (4th high sample): assert err, clear the partial word, go to DRAIN.
  - din=0, L=1: decode symbol 0. L=3: decode symbol 1. L=2: assert err, clear the partial word.
  - In every din=0 case, go to IDLE with gap counter=1.
- State DRAIN: ignore din=1. On din=0, go to IDLE with gap counter=1 and no further strobe. A stuck-high line yields exactly one err.
- Decode, on the edge sampling the falling din:
  - sym_valid=1 and sym_bit=symbol.
  - Shift the symbol into the LSB of the shift register and increment bit_count.
  - If bit_count reaches WIDTH: word_valid=1 in the same cycle as that final sym_valid, word_data loads the full register, bit_count returns to 0.
  - word_data holds its value until the next completed word. It is unchanged by err, abort, or reset release.
- The minimum legal gap between pulses is one low sample. Back-to-back pulses separated by a single 0 must both decode.
- err and abort are never asserted in the same cycle. sym_valid and err are mutually exclusive.
- Reset asserted mid-pulse or mid-word discards all progress. A line already high at reset release is measured from the first sampled 1, so the first pulse may decode short or err.

Test Plan:
- Reset, then with WIDTH=8 send pulses of lengths 3,1,3,3,1,1,3,1, each separated by 1 low cycle -> 8 sym_valid strobes. word_valid coincides with the 8th; word_data=8'hB2, then bit_count=0.
- Send a 2-cycle pulse after 3 valid symbols -> err for 1 cycle, no sym_valid, bit_count=0. A following full word decodes correctly.
- Hold din high for 10 cycles -> exactly one err, on the edge of the 4th high sample. Then din low, then a 1-cycle pulse -> sym_valid with sym_bit=0.
- Send 5 symbols, then hold din low for GAP_TIMEOUT=16 cycles -> abort for 1 cycle on the 16th low sample, bit_count=0, word_data unchanged. With bit_count=0, an idle line never aborts.
- Pull rst low asynchronously mid-pulse with 4 symbols held -> all outputs 0 immediately, without waiting for a clock edge. After release, a full word decodes with no stale bits.
- Drive the decoder from the generator FSM with x toggling randomly -> only symbol 0/1 strobes occur, never err.
